// File: rtl/smem_pkg.sv
// smem_pkg
// Shared definitions for the SMEM backward-extension path: status encodings,
// sizing constants, the 256-bit buffer entry layout and the drain FSM states.
// No ports; imported by the drain block and its entry RAM.
package smem_pkg;

  localparam int CL             = 64;
  localparam int MAX_READ       = 1024;
  localparam int READ_NUM_WIDTH = 10;

  // Forward / backward extension status codes carried alongside entries.
  localparam logic [2:0] F_init  = 3'd0;
  localparam logic [2:0] F_run   = 3'd1;
  localparam logic [2:0] F_break = 3'd2;
  localparam logic [2:0] BCK_INI = 3'd3;
  localparam logic [2:0] BCK_RUN = 3'd4;
  localparam logic [2:0] BCK_END = 3'd5;
  localparam logic [2:0] BUBBLE  = 3'd6;

  // One buffer entry; x0 sits in the most significant 64 bits so that
  // {mem_x_0, mem_x_1, mem_x_2, mem_x_info} packs directly into it.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] info;
  } smem_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } drain_state_t;

endpackage

// File: rtl/smem_mem_drain_if.sv
// smem_mem_drain_if
// Bundles the stage-1 write bus, the drain control inputs and the downstream
// valid/ready stream of smem_mem_drain.
//   slave  : view of the drain block (consumes writes/commands, drives stream)
//   master : view of the surrounding logic (stage 1, controller, consumer)
interface smem_mem_drain_if #(
  parameter int ADDR_W = 7,
  parameter int RN_W   = 10
);

  logic              store_valid_mem;
  logic [63:0]       mem_x_0;
  logic [63:0]       mem_x_1;
  logic [63:0]       mem_x_2;
  logic [63:0]       mem_x_info;
  logic [ADDR_W-1:0] mem_x_addr;

  logic              drain_start;
  logic [ADDR_W-1:0] drain_count;
  logic [RN_W-1:0]   drain_read_num;
  logic              busy;
  logic              drain_done;
  logic              wr_err;

  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_x0;
  logic [63:0]       out_x1;
  logic [63:0]       out_x2;
  logic [63:0]       out_info;
  logic [RN_W-1:0]   out_read_num;
  logic              out_last;

  modport slave (
    input  store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    input  drain_start, drain_count, drain_read_num, out_ready,
    output busy, drain_done, wr_err,
    output out_valid, out_x0, out_x1, out_x2, out_info, out_read_num, out_last
  );

  modport master (
    output store_valid_mem, mem_x_0, mem_x_1, mem_x_2, mem_x_info, mem_x_addr,
    output drain_start, drain_count, drain_read_num, out_ready,
    input  busy, drain_done, wr_err,
    input  out_valid, out_x0, out_x1, out_x2, out_info, out_read_num, out_last
  );

endinterface

// File: rtl/smem_entry_ram.sv
// smem_entry_ram
// DEPTH x 256-bit simple dual-port RAM: one write port, one synchronous read
// port with read enable. The read data register doubles as the output holding
// register of the drain stream, so it is cleared by reset and only updates
// when re is high; the array itself is never cleared.
// Ports: clk, rst (sync, active-low), we/waddr/wdata, re/raddr, rdata.
module smem_entry_ram
  import smem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  smem_entry_t       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output smem_entry_t       rdata
);

  smem_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/smem_mem_drain.sv
// smem_mem_drain
// Owns the SMEM result buffer filled by stage 1 and, on drain_start, streams
// entries 0..drain_count-1 downstream tagged with the read number.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   bus (slave modport) stage-1 writes, drain_start/count/read_num,
//                       busy/drain_done/wr_err, out_* valid/ready stream
module smem_mem_drain
  import smem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int RN_W   = 10
) (
  input logic              clk,
  input logic              rst,
  smem_mem_drain_if.slave  bus
);

  drain_state_t      state, state_next;
  logic [ADDR_W-1:0] idx, cnt;
  logic [RN_W-1:0]   read_num;
  logic              last_q;
  logic              wr_err_q;
  logic              start_acc, ram_re, beat_done;
  logic              wr_en;
  smem_entry_t       wr_entry, rd_entry;

  // Writes are only honoured while idle so a drain never sees the buffer move.
  assign wr_en    = bus.store_valid_mem && (state == IDLE);
  assign wr_entry = {bus.mem_x_0, bus.mem_x_1, bus.mem_x_2, bus.mem_x_info};

  smem_entry_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (bus.mem_x_addr),
    .wdata (wr_entry),
    .re    (ram_re),
    .raddr (idx),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    ram_re     = 1'b0;
    beat_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.drain_start) begin
          start_acc  = 1'b1;
          state_next = (bus.drain_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        ram_re     = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          beat_done  = 1'b1;
          state_next = last_q ? DONE : READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // READ is only reachable with cnt >= 1, so cnt - 1 never wraps here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx      <= '0;
      cnt      <= '0;
      read_num <= '0;
      last_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        cnt      <= bus.drain_count;
        read_num <= bus.drain_read_num;
        idx      <= '0;
      end
      if (ram_re) last_q <= (idx == cnt - 1'b1);
      if (beat_done) begin
        last_q <= 1'b0;
        if (!last_q) idx <= idx + 1'b1;
      end
      if (bus.store_valid_mem && (state != IDLE)) wr_err_q <= 1'b1;
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.drain_done   = (state == DONE);
  assign bus.out_valid    = (state == SEND);
  assign bus.out_last     = last_q;
  assign bus.out_read_num = read_num;
  assign bus.wr_err       = wr_err_q;
  assign bus.out_x0       = rd_entry.x0;
  assign bus.out_x1       = rd_entry.x1;
  assign bus.out_x2       = rd_entry.x2;
  assign bus.out_info     = rd_entry.info;

endmodule
